serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial add/subtract unit built around a single full-adder cell and a carry flip-flop. It accepts two WIDTH-bit operands on a start strobe and processes one bit per clock, LSB first. It returns the registered sum, carry-out and signed-overflow flag with a one-cycle done pulse. It is the sequential stage directly downstream of the combinational full adder: it consumes that cell's sum/carry outputs every cycle and feeds the carry back as the next carry-in.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = a+b+cin, 1 = a−b−cin (borrow-in)
- a  input  WIDTH  operand A, captured when start is accepted
- b  input  WIDTH  operand B, captured when start is accepted
- cin  input  1  carry-in (add) / borrow-in (sub), captured with operands
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result, held until next completion
- cout  output  1  carry-out; for sub, 1 = no borrow
- ovf  output  1  two's-complement overflow

## Operation
- States: IDLE, SHIFT, DONE. Reset puts the block in IDLE.
- IDLE, start=1: load a_sh=a, b_sh=(sub ? ~b : b), carry=cin^sub, bit counter=0, go to SHIFT. Otherwise stay in IDLE.
- SHIFT, each cycle:
  - s = a_sh[0]^b_sh[0]^carry; c = majority(a_sh[0], b_sh[0], carry).
  - Shift s into the MSB of sum_sh (right shift). Shift a_sh and b_sh right. carry←c.
  - On the bit with counter==WIDTH−1, save the carry-in of that bit as c_msb_in.
  - Counter increments. After WIDTH bits, go to DONE.
- Entering DONE: sum←sum_sh (final), cout←carry, ovf←carry^c_msb_in.
- DONE lasts one cycle, then returns to IDLE unconditionally. start is ignored in DONE.
- start in SHIFT or DONE is ignored, with no queueing. Changes on a, b, cin or sub after acceptance do not affect the result.
- Arithmetic is modulo 2^WIDTH. There are no exceptions and nothing saturates.

## Timing
- Reset (async assert, any state) forces:
  - state=IDLE, busy=0, done=0
  - sum=0, cout=0, ovf=0
  - all internal shift registers, carry and counter = 0
- Reset takes effect immediately without a clock. Release is synchronous to the next clk edge.
- Reset mid-SHIFT aborts the operation. No done is produced for it.
- Latency: start sampled at edge E0 → bits processed at E1…E_WIDTH → DONE entered at E_WIDTH.
  - done=1 and the new sum/cout/ovf are visible in the cycle after E_WIDTH.
  - IDLE is re-entered at E_WIDTH+1.
- busy=1 exactly in SHIFT (WIDTH cycles). busy=0 in IDLE and DONE.
- done=1 exactly in DONE. It is never high for two consecutive cycles.
- Back-to-back: start held high gives one accepted operation every WIDTH+2 cycles.
- Outputs sum/cout/ovf change only at DONE entry or reset.

## Test plan
All scenarios use WIDTH=8.
- Add 0x3C+0x0F, cin=0, one-cycle start → done exactly 8 edges after start edge; sum=0x4B, cout=0, ovf=0; busy high for 8 cycles.
- Add 0xFF+0x01, cin=1 → sum=0x01, cout=1, ovf=0. Add 0x7F+0x01, cin=0 → sum=0x80, cout=0, ovf=1.
- Sub 0x05−0x07, cin=0 → sum=0xFE, cout=0, ovf=0. Sub 0x80−0x01, cin=0 → sum=0x7F, cout=1, ovf=1.
- Start 0x10+0x20, then pulse start and change a=0xFF, b=0xFF, sub=1 during cycle 3 of busy → no restart; result sum=0x30, cout=0; a single done pulse.
- start held high for 30 cycles with fixed operands 0x01+0x01 → done pulses every 10 cycles; each sum=0x02.
- Assert rst_n=0 four cycles into an operation → busy, done, sum, cout, ovf all 0 immediately. No done follows. After release, 0x0A+0x05 completes with sum=0x0F.

Source files
------------

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result bundle for the bit-serial add/subtract unit
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract, one full-adder cell plus carry flop, LSB first
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic w_load;
    logic w_last;
    logic w_s;
    logic w_c;

    assign w_load = (r_state == S_IDLE) && bus.start;
    assign w_last = (r_state == S_SHIFT) && (r_cnt == LAST);
    assign w_s    = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_c    = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1 - borrow, so the inverted operand and carry are set up at load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_load) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.cin ^ bus.sub;
            r_cnt   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_carry  <= w_c;
            r_cnt    <= r_cnt + CW'(1);
            // On the MSB, r_carry is the carry into the sign bit; overflow is it XOR carry-out.
            if (w_last) begin
                r_sum  <= {w_s, r_sum_sh[WIDTH-1:1]};
                r_cout <= w_c;
                r_ovf  <= w_c ^ r_carry;
            end
        end
    end

    assign bus.busy = (r_state == S_SHIFT);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder with arithmetic reference model
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus();
    serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int           cyc;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int free_cyc = 0;
    int last_acc = -1000;
    int n_tests = 0;
    int n_fail = 0;
    logic [W-1:0] h_sum = '0;
    logic h_cout = 1'b0;
    logic h_ovf = 1'b0;

    function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input int at);
        exp_t e;
        int ua, ub, sa, sb, ci, r, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = int'(c);
        if (!s) begin
            r  = ua + ub + ci;
            sr = sa + sb + ci;
            e.cout = (r >= (1 << W));
        end else begin
            r  = ua - ub - ci;
            sr = sa - sb - ci;
            e.cout = (ua >= ub + ci);
        end
        e.sum = W'(r);
        e.ovf = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        e.cyc = at + W;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst_n === 1'b1 && bus.start && cyc >= free_cyc) begin
            q.push_back(model(bus.sub, bus.a, bus.b, bus.cin, cyc));
            last_acc = cyc;
            free_cyc = cyc + W + 2;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            begin
                logic exp_busy, exp_done;
                exp_busy = (cyc >= last_acc) && (cyc <= last_acc + W - 1);
                exp_done = (q.size() > 0) && (q[0].cyc == cyc);
                chk("busy", 32'(bus.busy), 32'(exp_busy));
                chk("done", 32'(bus.done), 32'(exp_done));
                if (exp_done) begin
                    exp_t e;
                    e = q.pop_front();
                    h_sum  = e.sum;
                    h_cout = e.cout;
                    h_ovf  = e.ovf;
                end
                chk("sum", 32'(bus.sum), 32'(h_sum));
                chk("cout", 32'(bus.cout), 32'(h_cout));
                chk("ovf", 32'(bus.ovf), 32'(h_ovf));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((q.size() > 0 || cyc < free_cyc) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout at cycle %0d: queue %0d expected 0", cyc, q.size());
        end
    endtask

    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input int hold);
        wait_idle();
        bus.sub = s;
        bus.a = a;
        bus.b = b;
        bus.cin = c;
        bus.start = 1'b1;
        repeat (hold) @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic clear_model();
        q.delete();
        last_acc = -1000;
        free_cyc = 0;
        h_sum = '0;
        h_cout = 1'b0;
        h_ovf = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_sum", 32'(bus.sum), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 8'h3C, 8'h0F, 1'b0, 1);
        run_op(1'b0, 8'hFF, 8'h01, 1'b1, 1);
        run_op(1'b0, 8'h7F, 8'h01, 1'b0, 1);
        run_op(1'b1, 8'h05, 8'h07, 1'b0, 1);
        run_op(1'b1, 8'h80, 8'h01, 1'b0, 1);

        run_op(1'b0, 8'h10, 8'h20, 1'b0, 1);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        bus.sub = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        run_op(1'b0, 8'h01, 8'h01, 1'b0, 30);

        run_op(1'b0, 8'h33, 8'h44, 1'b0, 1);
        repeat (3) @(negedge clk);
        #3;
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 8'h0A, 8'h05, 1'b0, 1);

        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                   int'($urandom_range(1, 14)));
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            bus.sub = 1'($urandom);
            bus.cin = 1'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
